// File: rtl/sccb_responder.sv
// sccb_responder: SCCB slave exposing a 64x8 register file. It supports a 3-phase write
// and a 2-phase pointer write followed by a 2-phase read. SIOD is open-drain and is only ever pulled low.
module sccb_responder #(
    parameter logic [7:0] DEV_ID  = 8'h42,
    parameter int         IN_FREQ = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sioc_i,
    inout  wire        siod_io,
    input  logic [5:0] host_addr_i,
    output logic [7:0] host_rdata_o,
    output logic       wr_stb_o,
    output logic [5:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o
);
    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t     state, state_n;
    logic [1:0] sioc_s, siod_s;
    logic       sioc, siod, sioc_q, siod_q;
    logic       rise, fall, start, stop;
    logic [7:0] sh, sh_n, ptr, ptr_n, rx_byte, rd_byte;
    logic [3:0] cnt, cnt_n;
    logic       drv, drv_n, we;
    logic [7:0] rf [64];

    if (IN_FREQ <= 0) begin : g_bad_freq
    end

    assign sioc    = sioc_s[1];
    assign siod    = siod_s[1];
    assign rise    = sioc & ~sioc_q;
    assign fall    = ~sioc & sioc_q;
    assign start   = sioc & sioc_q & siod_q & ~siod;
    assign stop    = sioc & sioc_q & ~siod_q & siod;
    assign rx_byte = {sh[6:0], siod};
    assign rd_byte = (ptr[7:6] == 2'b00) ? rf[ptr[5:0]] : 8'h00;
    assign siod_io = drv ? 1'b0 : 1'bz;
    assign busy_o  = state != IDLE;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_n;
    end

    // Ack states: first SIOC fall asserts the ACK, the fall after the 9th rise releases and branches.
    always_comb begin
        state_n = state;
        sh_n    = sh;
        ptr_n   = ptr;
        cnt_n   = cnt;
        drv_n   = drv;
        we      = 1'b0;
        if (start) begin
            state_n = ID;
            cnt_n   = '0;
            drv_n   = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            drv_n   = 1'b0;
        end else begin
            case (state)
                ID, SUB, WDATA: if (rise) begin
                    sh_n  = rx_byte;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        if (state == ID) begin
                            state_n = (rx_byte[7:1] == DEV_ID[7:1]) ? ID_ACK : WAIT_STOP;
                        end else if (state == SUB) begin
                            ptr_n   = rx_byte;
                            state_n = SUB_ACK;
                        end else begin
                            we      = ptr[7:6] == 2'b00;
                            state_n = WDATA_ACK;
                        end
                    end
                end
                ID_ACK, SUB_ACK, WDATA_ACK: if (rise) begin
                    cnt_n = 4'd9;
                end else if (fall) begin
                    drv_n = cnt == 4'd8;
                    if (cnt == 4'd9) begin
                        cnt_n   = '0;
                        state_n = (state == SUB_ACK) ? WDATA : (state == WDATA_ACK) ? WAIT_STOP : sh[0] ? RDATA : SUB;
                        if (state == ID_ACK && sh[0]) begin
                            sh_n  = rd_byte;
                            drv_n = ~rd_byte[7];
                        end
                    end
                end
                RDATA: if (rise) begin
                    cnt_n = cnt + 4'd1;
                end else if (fall) begin
                    sh_n  = {sh[6:0], sh[7]};
                    drv_n = (cnt != 4'd8) && !sh[6];
                    if (cnt == 4'd8) state_n = RD_ACK;
                end
                RD_ACK: if (rise) state_n = WAIT_STOP;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sioc_s       <= '1;
            siod_s       <= '1;
            sioc_q       <= 1'b1;
            siod_q       <= 1'b1;
            sh           <= '0;
            ptr          <= '0;
            cnt          <= '0;
            drv          <= 1'b0;
            wr_stb_o     <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            host_rdata_o <= '0;
            for (int i = 0; i < 64; i++) rf[i] <= '0;
        end else begin
            sioc_s       <= {sioc_s[0], sioc_i};
            siod_s       <= {siod_s[0], siod_io};
            sioc_q       <= sioc;
            siod_q       <= siod;
            sh           <= sh_n;
            ptr          <= ptr_n;
            cnt          <= cnt_n;
            drv          <= drv_n;
            wr_stb_o     <= we;
            host_rdata_o <= rf[host_addr_i];
            if (we) begin
                rf[ptr[5:0]] <= rx_byte;
                wr_addr_o    <= ptr[5:0];
                wr_data_o    <= rx_byte;
            end
        end
    end
endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: directed SCCB master driving the responder with a vector table plus corner-case sequences.
module tb_sccb_responder;
    localparam int Q = 8;

    typedef struct {
        logic [7:0] id, sub, dat;
        logic [2:0] ack;
        logic       stb;
        logic [5:0] haddr;
        logic [7:0] rd;
    } vec_t;

    logic       clk_i = 1'b0, rst_i = 1'b0, sioc = 1'b1, m_low = 1'b0;
    logic [5:0] host_addr = '0;
    logic [7:0] host_rdata, wr_data;
    logic [5:0] wr_addr;
    logic       wr_stb, busy;
    wire        siod;

    int         total = 0, bad = 0, stb_cnt = 0, stb_wide = 0;
    logic       prev_stb = 1'b0, cap = 1'b0, drv_seen = 1'b0;
    logic [7:0] rd_after = '0;

    assign siod = m_low ? 1'b0 : 1'bz;
    pullup (siod);

    always #5 clk_i = ~clk_i;

    sccb_responder dut (
        .clk_i(clk_i), .rst_i(rst_i), .sioc_i(sioc), .siod_io(siod),
        .host_addr_i(host_addr), .host_rdata_o(host_rdata), .wr_stb_o(wr_stb),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy)
    );

    always @(negedge clk_i) begin
        #1;
        if (cap) begin
            rd_after = host_rdata;
            cap = 1'b0;
        end
        if (wr_stb) begin
            stb_cnt++;
            cap = 1'b1;
        end
        if (wr_stb && prev_stb) stb_wide++;
        prev_stb = wr_stb;
        if (!m_low && siod === 1'b0) drv_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic start_c;
        m_low = 1'b0; tick(Q); sioc = 1'b1; tick(Q); m_low = 1'b1; tick(Q); sioc = 1'b0; tick(Q);
    endtask

    task automatic stop_c;
        m_low = 1'b1; tick(Q); sioc = 1'b1; tick(Q); m_low = 1'b0; tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic do_ack, output logic ack);
        ack = 1'b0;
        for (int i = 7; i > 7 - n; i--) begin
            m_low = ~b[i]; tick(Q); sioc = 1'b1; tick(Q); sioc = 1'b0; tick(Q);
        end
        if (do_ack) begin
            m_low = 1'b0; tick(Q); sioc = 1'b1; tick(Q / 2);
            ack = (siod == 1'b0);
            tick(Q / 2); sioc = 1'b0; tick(Q);
        end
    endtask

    task automatic read_byte(output logic [7:0] b, output logic rel);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            tick(Q); sioc = 1'b1; tick(Q / 2); b[i] = siod; tick(Q / 2); sioc = 1'b0;
        end
        tick(Q); sioc = 1'b1; tick(Q / 2);
        rel = (siod == 1'b1);
        tick(Q / 2); sioc = 1'b0; tick(Q);
    endtask

    task automatic xfer(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] dat,
                        input int n, output logic [2:0] acks);
        logic a;
        start_c;
        send_bits(id, 8, 1'b1, a);  acks[2] = a;
        send_bits(sub, 8, 1'b1, a); acks[1] = a;
        acks[0] = 1'b0;
        if (n == 3) begin
            send_bits(dat, 8, 1'b1, a);
            acks[0] = a;
        end
        stop_c;
    endtask

    initial begin
        vec_t       v [7];
        logic [2:0] acks;
        logic       a, rel;
        logic [7:0] rb;
        int         s0;
        v[0] = '{8'h42, 8'h12, 8'h80, 3'b111, 1'b1, 6'h12, 8'h80};
        v[1] = '{8'h42, 8'h07, 8'h5A, 3'b111, 1'b1, 6'h07, 8'h5A};
        v[2] = '{8'h60, 8'h12, 8'h55, 3'b000, 1'b0, 6'h12, 8'h80};
        v[3] = '{8'h42, 8'h50, 8'hAA, 3'b111, 1'b0, 6'h10, 8'h00};
        v[4] = '{8'h42, 8'h3F, 8'hFF, 3'b111, 1'b1, 6'h3F, 8'hFF};
        v[5] = '{8'h44, 8'h07, 8'h11, 3'b000, 1'b0, 6'h07, 8'h5A};
        v[6] = '{8'h42, 8'h00, 8'h01, 3'b111, 1'b1, 6'h00, 8'h01};

        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_stb", wr_stb, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_waddr", wr_addr, 0);
        chk("rst_wdata", wr_data, 0);
        chk("rst_siod", siod, 1);
        rst_i = 1'b1;
        tick(4);

        for (int k = 0; k < 7; k++) begin
            host_addr = v[k].haddr;
            s0 = stb_cnt;
            drv_seen = 1'b0;
            xfer(v[k].id, v[k].sub, v[k].dat, 3, acks);
            tick(2);
            chk($sformatf("v%0d_ack", k), acks, v[k].ack);
            chk($sformatf("v%0d_stb", k), stb_cnt - s0, v[k].stb);
            chk($sformatf("v%0d_busy", k), busy, 0);
            chk($sformatf("v%0d_rdata", k), host_rdata, v[k].rd);
            if (v[k].stb) begin
                chk($sformatf("v%0d_waddr", k), wr_addr, v[k].sub[5:0]);
                chk($sformatf("v%0d_wdata", k), wr_data, v[k].dat);
                chk($sformatf("v%0d_rd_next", k), rd_after, v[k].dat);
            end
            if (v[k].ack == 3'b000) chk($sformatf("v%0d_nodrive", k), drv_seen, 0);
        end

        s0 = stb_cnt;
        start_c;
        send_bits(8'h42, 8, 1'b1, a); chk("p2_id_ack", a, 1);
        send_bits(8'h12, 8, 1'b1, a); chk("p2_sub_ack", a, 1);
        chk("p2_busy", busy, 1);
        stop_c; tick(2);
        chk("p2_idle", busy, 0);
        start_c;
        send_bits(8'h43, 8, 1'b1, a); chk("rd_id_ack", a, 1);
        read_byte(rb, rel);
        stop_c; tick(2);
        chk("rd_data", rb, 8'h80);
        chk("rd_rel9", rel, 1);
        chk("rd_busy", busy, 0);
        chk("p2_no_stb", stb_cnt - s0, 0);

        xfer(8'h42, 8'h50, 8'h00, 2, acks);
        chk("hi_p2_ack", acks, 3'b110);
        start_c;
        send_bits(8'h43, 8, 1'b1, a); chk("hi_rd_ack", a, 1);
        read_byte(rb, rel);
        stop_c; tick(2);
        chk("hi_rd_data", rb, 8'h00);
        chk("hi_no_stb", stb_cnt - s0, 0);

        s0 = stb_cnt;
        host_addr = 6'h05;
        start_c;
        send_bits(8'h42, 8, 1'b1, a);
        send_bits(8'h09, 4, 1'b0, a);
        xfer(8'h42, 8'h05, 8'h3C, 3, acks);
        tick(2);
        chk("rs_ack", acks, 3'b111);
        chk("rs_stb", stb_cnt - s0, 1);
        chk("rs_waddr", wr_addr, 6'h05);
        chk("rs_wdata", wr_data, 8'h3C);
        chk("rs_rdata", host_rdata, 8'h3C);
        host_addr = 6'h07; tick(2);
        chk("rs_keep", host_rdata, 8'h5A);

        host_addr = 6'h12;
        start_c;
        send_bits(8'h42, 8, 1'b0, a);
        m_low = 1'b0; tick(Q);
        chk("ack_driven", siod, 0);
        chk("ack_busy", busy, 1);
        rst_i = 1'b0; #1;
        chk("arst_siod", siod, 1);
        chk("arst_busy", busy, 0);
        chk("arst_stb", wr_stb, 0);
        chk("arst_rdata", host_rdata, 0);
        chk("arst_waddr", wr_addr, 0);
        chk("arst_wdata", wr_data, 0);
        tick(2);
        rst_i = 1'b1;
        stop_c; tick(2);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rf", host_rdata, 0);
        xfer(8'h42, 8'h12, 8'h80, 3, acks);
        tick(2);
        chk("post_rst_ack", acks, 3'b111);
        chk("post_rst_rdata", host_rdata, 8'h80);
        chk("stb_width", stb_wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sccb_responder.md
SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 Parameter DEV_ID, default 8'h42, 8-bit device ID; bit 0 is ignored in compares.
REQ-002 Parameter IN_FREQ, default 50_000_000, clk_i frequency in Hz; informational only, because no timing in this block depends on it.
REQ-003 clk_i  input  1  main clock; one clock domain; every register changes on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low (0 - reset).
REQ-005 sioc_i  input  1  SCCB clock from the master, asynchronous to clk_i.
REQ-006 siod_io  inout  1  SCCB data line, open-drain; the block drives 1'b0 only, otherwise 1'bz; an external pull-up is present.
REQ-007 host_addr_i  input  6  fabric-side register read address.
REQ-008 host_rdata_o  output  8  register contents at host_addr_i.
REQ-009 wr_stb_o  output  1  one-cycle pulse for each register written over SCCB.
REQ-010 wr_addr_o  output  6  sub-address of the last SCCB write.
REQ-011 wr_data_o  output  8  data of the last SCCB write.
REQ-012 busy_o  output  1  high while any transaction is in progress, i.e. FSM not in IDLE.

Function
REQ-013 sioc_i and siod_io input each pass through a 2-FF synchronizer; all edge and condition detection uses the synchronized copies and their previous values.
REQ-014 START: synchronized SIOD falls while synchronized SIOC is high; from any state -> ID, bit counter 0, drive released.
REQ-015 STOP: synchronized SIOD rises while synchronized SIOC is high; from any state -> IDLE, drive released, pointer kept.
REQ-016 Receive bits on the SIOC rising edge, MSB first, shifting into an 8-bit shift register; 8 bits complete a byte.
REQ-017 Drive changes (assert or release) occur only in the clk_i cycle after a detected SIOC falling edge; siod_io never changes while SIOC is high except on START/STOP release.
REQ-018 FSM states: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT_STOP.
REQ-019 ID (8 bits received): if byte[7:1]==DEV_ID[7:1], go to ID_ACK; otherwise go to WAIT_STOP and never drive the line.
REQ-020 ID_ACK: drive low for the 9th bit (SCCB don't-care bit). At the 9th falling edge, release and branch on the R/W bit: byte[0]=0 -> SUB; byte[0]=1 -> RDATA, loading regfile[pointer] into the shift register and driving its MSB.
REQ-021 SUB: the received byte is loaded into the 8-bit pointer, then the FSM goes to SUB_ACK, which drives low for the 9th bit. At the 9th falling edge, release and go to WDATA.
REQ-022 WDATA: on the received byte:
- if pointer<64: write regfile[pointer[5:0]], set wr_addr_o/wr_data_o, and pulse wr_stb_o for exactly one cycle;
- if pointer>=64: no write and no strobe, but the byte is still ACKed.
Then go to WDATA_ACK (drive low for the 9th bit), then WAIT_STOP.
REQ-023 RDATA: after each SIOC falling edge, drive low when the current shift bit is 0, else release; 8 bits MSB first. Then release for the 9th bit and go to RD_ACK.
REQ-024 RD_ACK: the master's 9th bit is sampled and ignored; go to WAIT_STOP. Only one byte is returned per read.
REQ-025 Read data for pointer>=64 is 8'h00.
REQ-026 WAIT_STOP: siod_io released and clocks ignored until STOP (-> IDLE) or START (-> ID).
REQ-027 A 2-phase write (ID, SUB, then STOP) updates only the pointer; a following read transaction returns regfile[pointer].
REQ-028 host_rdata_o is registered: it equals regfile[host_addr_i] sampled one clk_i cycle earlier. A simultaneous SCCB write to the same address shows the new value one cycle after the write cycle.

Reset
REQ-029 While rst_i==0 (asynchronous):
- FSM in IDLE; siod_io released (z);
- regfile all 8'h00; pointer 0; shift register 0; bit counter 0;
- wr_stb_o, busy_o, host_rdata_o, wr_addr_o, wr_data_o all 0;
- synchronizers preset to 1 (idle bus).
REQ-030 Reset asserted mid-transaction releases siod_io immediately. After reset deasserts, the block ignores bus activity until the next START.

Verification
REQ-031 3-phase write 0x42, 0x12, 0x80 -> ACK low on all three 9th bits; wr_stb_o one pulse with wr_addr_o=6'h12, wr_data_o=8'h80; host_addr_i=6'h12 gives host_rdata_o=8'h80 one cycle later.
REQ-032 2-phase write 0x42, 0x12 + STOP, then read 0x43 -> returns 8'h80 MSB first; siod_io released on the 9th bit; busy_o=0 after STOP.
REQ-033 ID 0x60 -> siod_io never driven for the whole transaction; no wr_stb_o; regfile unchanged.
REQ-034 Write 0x42, 0x50, 0xAA (sub-address >=64) -> all bytes ACKed; no wr_stb_o; a subsequent read of 0x50 returns 8'h00.
REQ-035 START repeated during SUB, then a full write 0x42, 0x05, 0x3C -> only regfile[5]=8'h3C is written. Separately, rst_i=0 while the block drives ACK -> siod_io=z within the same cycle, and all outputs return to their reset values.
